// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory.
// Size codes, FSM state, response metadata and lane masks.
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  typedef struct packed {
    logic       we;
    logic       err;
    logic       uns;
    logic [1:0] size;
    logic [1:0] off;
  } rsp_meta_t;

  // Bit i enables lane i; lane 0 holds bits [31:24].
  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_BYTE: m = 4'b0001 << off;
      SIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// dmem_lane_ram: one byte lane of the data memory.
// Write enable plus synchronous, enable-gated read.
module dmem_lane_ram #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [WORDS];

  // Storage is never reset; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_bus.sv
// dmem_bus: big-endian byte/half/word data memory with a
// valid/ready request port and one registered response stage.
module dmem_bus
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWe,
  input  logic [1:0]        reqSize,
  input  logic              reqUnsigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] rspData,
  output logic              rspErr
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (AW > 2) ? AW - 2 : 1;

  state_t          state;
  state_t          state_n;
  rsp_meta_t       meta;
  logic            accept;
  logic            req_err;
  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   addr_m;
  logic [IDX_W-1:0] idx;
  logic [3:0]      mask;
  logic [DATA_W-1:0] wsteer;
  logic [7:0]      wlane [4];
  logic [7:0]      rlane [4];
  logic [7:0]      b;
  logic [15:0]     h;
  logic [DATA_W-1:0] rdata;
  logic            unused_hi;

  assign addr_m    = reqAddr[AW-1:0];
  assign unused_hi = ^(reqAddr >> AW);
  assign idx       = IDX_W'(addr_m >> 2);
  assign mask      = lane_mask(reqSize, addr_m[1:0]);

  // Alignment and size legality of the presented request.
  always_comb begin
    req_err = 1'b0;
    case (reqSize)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = addr_m[0];
      SIZE_WORD: req_err = |addr_m[1:0];
      default:   req_err = 1'b1;
    endcase
  end

  // Handshake next-state and request-side ready.
  always_comb begin
    state_n  = state;
    reqReady = (state == IDLE) || rspReady;
    accept   = reqValid && reqReady;
    unique case (state)
      IDLE: if (accept) state_n = RESP;
      RESP: begin
        if (accept)        state_n = RESP;
        else if (rspReady) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Capture what the response needs to format the read lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
    end else if (accept) begin
      meta <= '{we:   reqWe,
                err:  req_err,
                uns:  reqUnsigned,
                size: reqSize,
                off:  addr_m[1:0]};
    end
  end

  assign wr_en = accept && reqWe && !req_err;
  assign rd_en = accept && !reqWe && !req_err;

  // Replicate store data so every lane sees its big-endian byte.
  always_comb begin
    wsteer = reqWdata;
    case (reqSize)
      SIZE_BYTE: wsteer = {4{reqWdata[7:0]}};
      SIZE_HALF: wsteer = {2{reqWdata[15:0]}};
      default:   wsteer = reqWdata;
    endcase
    for (int i = 0; i < 4; i++) begin
      wlane[i] = wsteer[8*(3-i) +: 8];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dmem_lane_ram #(
      .WORDS (WORDS),
      .IDX_W (IDX_W)
    ) u_ram (
      .clk   (clk),
      .we    (wr_en && mask[i]),
      .re    (rd_en),
      .addr  (idx),
      .wdata (wlane[i]),
      .rdata (rlane[i])
    );
  end

  // Right-align the addressed lanes and extend; zero otherwise.
  always_comb begin
    b     = rlane[meta.off];
    h     = meta.off[1] ? {rlane[2], rlane[3]}
                        : {rlane[0], rlane[1]};
    rdata = '0;
    if (rspValid && !meta.err && !meta.we) begin
      case (meta.size)
        SIZE_BYTE: rdata = {{24{b[7] & ~meta.uns}}, b};
        SIZE_HALF: rdata = {{16{h[15] & ~meta.uns}}, h};
        SIZE_WORD: rdata = {rlane[0], rlane[1],
                            rlane[2], rlane[3]};
        default:   rdata = '0;
      endcase
    end
  end

  assign rspValid = (state == RESP);
  assign rspData  = rdata;
  assign rspErr   = rspValid && meta.err;

endmodule

// File: tb/tb_dmem_bus.sv
// tb_dmem_bus: directed stimulus with a byte-array reference model
// compared every cycle, plus literal expectations.
module tb_dmem_bus;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic        reqUnsigned = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        rspValid;
  logic        rspReady = 1'b1;
  logic [31:0] rspData;
  logic        rspErr;

  int n_chk = 0;
  int n_pass = 0;

  dmem_bus #(
    .DEPTH_BYTES (DEPTH),
    .ADDR_W      (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqWe       (reqWe),
    .reqSize     (reqSize),
    .reqUnsigned (reqUnsigned),
    .reqAddr     (reqAddr),
    .reqWdata    (reqWdata),
    .rspValid    (rspValid),
    .rspReady    (rspReady),
    .rspData     (rspData),
    .rspErr      (rspErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // Reference model: flat byte array, big-endian, response queue of one.
  logic [7:0]  mm [DEPTH];
  bit          have = 0;
  logic [31:0] e_data = '0;
  logic        e_err = 1'b0;

  task automatic model_acc(input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] ad,
                           input logic [31:0] wd,
                           output logic [31:0] d, output logic e);
    int a;
    int n;
    logic [31:0] v;
    a = int'(ad % DEPTH);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || ((a % n) != 0);
    d = '0;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < n; k++)
          mm[a+k] = 8'(wd >> (8 * (n - 1 - k)));
      end else begin
        v = '0;
        for (int k = 0; k < n; k++)
          v = (v << 8) | 32'(mm[a+k]);
        if (n < 4 && !uns && v[8*n-1])
          v = v | (32'hFFFF_FFFF << (8 * n));
        d = v;
      end
    end
  endtask

  // Compare every cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [31:0] d;
    logic        e;
    if (!rst_n) begin
      chk("rst_valid", 32'(rspValid), 32'd0);
      chk("rst_data", rspData, 32'd0);
      chk("rst_err", 32'(rspErr), 32'd0);
      have = 0;
    end else begin
      chk("mon_ready", 32'(reqReady), 32'(!have || rspReady));
      chk("mon_valid", 32'(rspValid), 32'(have));
      if (have) begin
        chk("mon_data", rspData, e_data);
        chk("mon_err", 32'(rspErr), 32'(e_err));
      end
      if (reqValid && (!have || rspReady)) begin
        model_acc(reqWe, reqSize, reqUnsigned, reqAddr, reqWdata, d, e);
        e_data = d;
        e_err  = e;
        have   = 1;
      end else if (rspReady) begin
        have = 0;
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] ad,
                       input logic [31:0] wd);
    reqValid    = 1'b1;
    reqWe       = we;
    reqSize     = sz;
    reqUnsigned = uns;
    reqAddr     = ad;
    reqWdata    = wd;
  endtask

  // Single request with literal expectation; starts just after a rising edge.
  task automatic txn(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] ad,
                     input logic [31:0] wd, input string nm,
                     input logic [31:0] ed, input logic ee);
    drive(we, sz, uns, ad, wd);
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rspValid), 32'd1);
    chk({nm, "_data"}, rspData, ed);
    chk({nm, "_err"}, 32'(rspErr), 32'(ee));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] l_ad  [4];
  logic [1:0]  l_sz  [4];
  logic        l_un  [4];
  logic [31:0] l_exp [4];
  logic [31:0] held;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rspValid), 32'd0);
    chk("reset_data", rspData, 32'd0);
    chk("reset_err", 32'(rspErr), 32'd0);
    rst_n = 1'b1;
    #1 chk("reset_ready", 32'(reqReady), 32'd1);
    @(posedge clk);
    #1;

    txn(1, 2'b10, 0, 32'h10, 32'h1234_5678, "st_w10", 32'h0, 0);
    txn(0, 2'b10, 0, 32'h10, 32'h0, "ld_w10", 32'h1234_5678, 0);
    txn(0, 2'b00, 1, 32'h10, 32'h0, "ld_bu10", 32'h0000_0012, 0);
    txn(1, 2'b00, 0, 32'h13, 32'hF8, "st_b13", 32'h0, 0);
    txn(0, 2'b00, 0, 32'h13, 32'h0, "ld_bs13", 32'hFFFF_FFF8, 0);
    txn(0, 2'b00, 1, 32'h13, 32'h0, "ld_bu13", 32'h0000_00F8, 0);
    txn(0, 2'b01, 0, 32'h12, 32'h0, "ld_hs12", 32'h0000_56F8, 0);
    txn(1, 2'b01, 0, 32'h12, 32'hBEEF, "st_h12", 32'h0, 0);
    txn(0, 2'b10, 0, 32'h10, 32'h0, "ld_w10b", 32'h1234_BEEF, 0);
    txn(1, 2'b00, 0, 32'h11, 32'hAA, "st_b11", 32'h0, 0);
    txn(0, 2'b10, 0, 32'h10, 32'h0, "ld_w10c", 32'h12AA_BEEF, 0);

    txn(0, 2'b01, 0, 32'h11, 32'h0, "err_h11", 32'h0, 1);
    txn(1, 2'b10, 0, 32'h12, 32'hDEAD_BEEF, "err_w12", 32'h0, 1);
    txn(0, 2'b11, 0, 32'h10, 32'h0, "err_sz3", 32'h0, 1);
    txn(1, 2'b11, 0, 32'h10, 32'h0, "err_sz3st", 32'h0, 1);
    txn(0, 2'b10, 0, 32'h10, 32'h0, "ld_after_err", 32'h12AA_BEEF, 0);

    txn(0, 2'b10, 0, 32'h410, 32'h0, "alias_410", 32'h12AA_BEEF, 0);
    txn(1, 2'b10, 0, 32'hFFFF_F3FC, 32'hCAFE_F00D, "st_top", 32'h0, 0);
    txn(0, 2'b00, 1, 32'h3FF, 32'h0, "ld_bu3ff", 32'h0000_000D, 0);
    txn(0, 2'b01, 0, 32'h3FC, 32'h0, "ld_hs3fc", 32'hFFFF_CAFE, 0);

    drive(1, 2'b10, 0, 32'h20, 32'h0102_0304);
    @(posedge clk);
    #1 drive(0, 2'b10, 0, 32'h20, 32'h0);
    @(negedge clk);
    chk("b2b_st_data", rspData, 32'h0);
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    chk("b2b_ld_data", rspData, 32'h0102_0304);
    @(posedge clk);
    #1;

    drive(1, 2'b00, 0, 32'h21, 32'h55);
    @(posedge clk);
    #1 drive(0, 2'b00, 1, 32'h22, 32'h0);
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    chk("lane_ld_b22", rspData, 32'h0000_0003);
    @(posedge clk);
    #1;
    txn(0, 2'b10, 0, 32'h20, 32'h0, "lane_w20", 32'h0155_0304, 0);

    l_ad[0] = 32'h10; l_sz[0] = 2'b10; l_un[0] = 0;
    l_exp[0] = 32'h12AA_BEEF;
    l_ad[1] = 32'h11; l_sz[1] = 2'b00; l_un[1] = 1;
    l_exp[1] = 32'h0000_00AA;
    l_ad[2] = 32'h12; l_sz[2] = 2'b01; l_un[2] = 1;
    l_exp[2] = 32'h0000_BEEF;
    l_ad[3] = 32'h13; l_sz[3] = 2'b00; l_un[3] = 0;
    l_exp[3] = 32'hFFFF_FFEF;

    rspReady = 1'b0;
    drive(0, l_sz[0], l_un[0], l_ad[0], 32'h0);
    @(posedge clk);
    @(negedge clk);
    held = rspData;
    chk("stall_first", held, 32'h12AA_BEEF);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_ready", 32'(reqReady), 32'd0);
      chk("stall_valid", 32'(rspValid), 32'd1);
      chk("stall_data", rspData, held);
    end
    @(posedge clk);
    #1 rspReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) drive(0, l_sz[i+1], l_un[i+1], l_ad[i+1], 32'h0);
      else reqValid = 1'b0;
      @(negedge clk);
      chk("thru_valid", 32'(rspValid), 32'd1);
      chk("thru_data", rspData, l_exp[i]);
    end
    @(posedge clk);
    #1;

    rspReady = 1'b0;
    drive(0, 2'b10, 0, 32'h20, 32'h0);
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    chk("rst_pend_valid", 32'(rspValid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rspValid), 32'd0);
    chk("rst_mid_data", rspData, 32'd0);
    chk("rst_mid_err", 32'(rspErr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rspReady = 1'b1;
    #1 chk("rst_after_ready", 32'(reqReady), 32'd1);
    chk("rst_after_valid", 32'(rspValid), 32'd0);
    @(posedge clk);
    #1;
    txn(0, 2'b10, 0, 32'h10, 32'h0, "keep_w10", 32'h12AA_BEEF, 0);
    txn(0, 2'b10, 0, 32'h20, 32'h0, "keep_w20", 32'h0155_0304, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_bus.md
# dmem_bus

Parametrised data memory for the MIPS datapath, with a request/response handshake between the MEM stage and storage. It supports byte, halfword and word loads/stores, big-endian byte order, sign/zero extension of loads and alignment checking. It has one registered response stage, so a new request can be accepted every cycle while the consumer keeps taking responses.

## Interface
- `DEPTH_BYTES`, default 1024: storage size in bytes; power of two, at least 4.
- `ADDR_W`, default 32: request address width.
- `clk`, input, 1 bit: clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `reqValid`, input, 1 bit: request present.
- `reqReady`, output, 1 bit: block can accept a request this cycle.
- `reqWe`, input, 1 bit: 1 = store, 0 = load.
- `reqSize`, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `reqUnsigned`, input, 1 bit: load zero-extends when 1, sign-extends when 0.
- `reqAddr`, input, ADDR_W bits: byte address. Masked to log2(DEPTH_BYTES) bits; upper bits are ignored.
- `reqWdata`, input, 32 bits: store data, right-aligned.
- `rspValid`, output, 1 bit: response present.
- `rspReady`, input, 1 bit: consumer takes the response.
- `rspData`, output, 32 bits: load result. It is 0 for stores and for errors.
- `rspErr`, output, 1 bit: misaligned address or illegal size.

## Operation
- FSM states:
  - IDLE: no response held.
  - RESP: response held on `rspValid`/`rspData`/`rspErr`.
- `reqReady` = (state == IDLE) || rspReady.
- Accept = reqValid && reqReady.
- Transitions:
  - IDLE → RESP on accept.
  - RESP → RESP on accept; the response register reloads.
  - RESP → IDLE on rspReady && !accept.
  - Otherwise the state holds.
- Response outputs are stable while rspValid && !rspReady.
- Every accepted request, load or store, produces exactly one response.
- Alignment rules:
  - Halfword requires a[0] = 0.
  - Word requires a[1:0] = 00.
  - Size 11 is always an error.
- On error: no storage write, rspErr = 1, rspData = 0.
- Big-endian: the byte at word offset 0 is bits [31:24] of the word.
  - Byte store writes reqWdata[7:0] to address a.
  - Halfword store writes reqWdata[15:8] to a and reqWdata[7:0] to a+1.
  - Word store writes 4 bytes MSB-first.
- Loads return the addressed bytes right-aligned.
  - Bits above the access size are sign-extended (reqUnsigned = 0) or zero-filled (reqUnsigned = 1).
  - reqUnsigned is ignored for word loads.
- Address wrap: the masked address never exceeds DEPTH_BYTES-1. Aligned accesses never cross the top.

## Timing
- Store bytes commit on the accepting rising edge.
- Load data is read from storage on the accepting edge and registered into rspData. rspValid rises on that same edge, so latency is 1 cycle.
- Throughput is 1 request/cycle while rspReady = 1.
- Back-to-back store then load to the same address, accepted on consecutive edges: the load returns the new data.
- Load and store to different bytes of one word on consecutive edges: each touches only its own byte lanes.
- Reset (asserted at any time):
  - state = IDLE, rspValid = 0, rspData = 0, rspErr = 0.
  - reqReady = 1 once reset deasserts.
  - A response pending at reset is dropped.
  - A store committed before reset assertion stays in storage.
- Storage is not reset; loads before any store return X.

## Structure
- Package `dmem_pkg`:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - FSM state enum (IDLE, RESP).
  - DATA_W = 32.
  - Lane-enable function: size + a[1:0] → 4-bit big-endian lane mask.
- Sub-module `dmem_lane_ram`: one byte-wide array of DEPTH_BYTES/4 entries with write enable and synchronous read. Four instances, lane 0 = bits [31:24].
- Top level holds the handshake FSM, alignment check, store-data steering and load extraction/extension.

## Test plan
- Word store 0x12345678 @0x10, then word load @0x10 → rspData = 0x12345678, rspErr = 0; byte load @0x10 unsigned → 0x00000012.
- Byte load @0x13 of 0x123456F8: signed → 0xFFFFFFF8, unsigned → 0x000000F8. Halfword load @0x12 signed → 0x000056F8.
- Halfword store 0xBEEF @0x12 over 0x12345678 → word load @0x10 = 0x1234BEEF. Byte store 0xAA @0x11 → 0x12AABEEF.
- Halfword load @0x11, word store @0x12, size 11 @0x10 → rspErr = 1, rspData = 0 each time; word @0x10 unchanged.
- Stall: hold rspReady = 0 for 3 cycles with reqValid = 1 → reqReady = 0 and response stable. Then rspReady = 1 with 4 consecutive loads → one response per cycle, in order.
- Address 0x400 + 0x10 with DEPTH_BYTES = 1024 aliases to 0x10. Assert rst_n = 0 mid-stall → rspValid = 0 immediately, stored data retained afterwards.
